q2_lcd_ctrl: RTL and testbench

Q2_LCD_CTRL -- requirements
Module: q2_lcd_ctrl

---
 rtl/q2_lcd_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_q2_lcd_ctrl.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q2_lcd_ctrl.sv
// HD44780-style character LCD controller: CPU write FIFO, power-on init
// sequence and setup/pulse/hold/settle timing for every LCD bus cycle.
module q2_lcd_ctrl #(
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 4,
  parameter int HOLD_CYC     = 2,
  parameter int WAIT_CYC     = 40,
  parameter int CLR_WAIT_CYC = 1600,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [11:0] dbus,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [7:0]  lcd_d,
  output logic        full,
  output logic        busy,
  output logic        overflow
);

  localparam int M0   = (CLR_WAIT_CYC > WAIT_CYC) ? CLR_WAIT_CYC : WAIT_CYC;
  localparam int M1   = (M0 > PULSE_CYC) ? M0 : PULSE_CYC;
  localparam int M2   = (M1 > SETUP_CYC) ? M1 : SETUP_CYC;
  localparam int CMAX = (M2 > HOLD_CYC) ? M2 : HOLD_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_e;

  function automatic logic [7:0] init_byte(input logic [1:0] s);
    logic [7:0] b;
    case (s)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h06;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  logic [1:0]    sync_q;
  logic          run;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    step_q, step_d;
  logic          rs_q, rs_d;
  logic [7:0]    d_q, d_d;
  logic          e_q, e_d;
  logic          full_q, full_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [8:0]    head;
  logic          pop, push;
  logic          keep, xrs;
  logic [7:0]    xd;
  logic          unused_hi;

  assign unused_hi = ^dbus[11:9];
  assign run       = sync_q[1];
  assign head      = mem_q[rptr_q];

  always_comb begin
    keep = 1'b1;
    xrs  = 1'b1;
    xd   = head[7:0];
    unique case (1'b1)
      !head[8]: begin
        xrs = 1'b1;
        if (head[7:0] < 8'h20 || head[7:0] > 8'h7E) xd = 8'h3F;
      end
      head[8] && head[7]: begin
        xrs = 1'b0;
        xd  = {1'b1, head[6:0]};
      end
      head[8] && !head[7] && head[0]: begin
        xrs = 1'b0;
        xd  = 8'h01;
      end
      default: keep = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    rs_d    = rs_q;
    d_d     = d_q;
    e_d     = e_q;
    pop     = 1'b0;
    if (run) begin
      unique case (state_q)
        S_INIT: begin
          d_d     = init_byte(step_q[1:0]);
          rs_d    = 1'b0;
          step_d  = step_q + 3'd1;
          cnt_d   = CW'(SETUP_CYC - 1);
          state_d = S_SETUP;
        end
        S_IDLE: begin
          if (count_q != '0) begin
            pop = 1'b1;
            if (keep) begin
              rs_d    = xrs;
              d_d     = xd;
              cnt_d   = CW'(SETUP_CYC - 1);
              state_d = S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            e_d     = 1'b1;
            cnt_d   = CW'(PULSE_CYC - 1);
            state_d = S_PULSE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            e_d     = 1'b0;
            cnt_d   = CW'(HOLD_CYC - 1);
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            // A clear instruction needs the long settle time.
            if (!rs_q && d_q == 8'h01) cnt_d = CW'(CLR_WAIT_CYC - 1);
            else                       cnt_d = CW'(WAIT_CYC - 1);
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d = (step_q == 3'd4) ? S_IDLE : S_INIT;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_comb begin
    push    = run && wr && ((count_q != DEPTH_V) || pop);
    ovf_d   = ovf_q || (run && wr && !push);
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_V);
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= S_INIT;
      cnt_q   <= '0;
      step_q  <= 3'd0;
      rs_q    <= 1'b0;
      d_q     <= 8'h00;
      e_q     <= 1'b0;
      full_q  <= 1'b0;
      busy_q  <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], 1'b1};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      rs_q    <= rs_d;
      d_q     <= d_d;
      e_q     <= e_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= dbus[8:0];
  end

  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign lcd_d    = d_q;
  assign full     = full_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_q2_lcd_ctrl.sv
// Bench for q2_lcd_ctrl: LCD bus monitor plus a queue model of the
// bytes the controller should emit for each CPU write sequence.
module tb_q2_lcd_ctrl;

  localparam int SETUP = 2;
  localparam int PULSE = 4;
  localparam int HOLD  = 2;
  localparam int WAITC = 40;
  localparam int CLRW  = 1600;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic [11:0] dbus;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic [7:0]  lcd_d;
  logic        full;
  logic        busy;
  logic        overflow;

  q2_lcd_ctrl #(
    .SETUP_CYC(SETUP),
    .PULSE_CYC(PULSE),
    .HOLD_CYC(HOLD),
    .WAIT_CYC(WAITC),
    .CLR_WAIT_CYC(CLRW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr(wr),
    .dbus(dbus),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_e(lcd_e),
    .lcd_d(lcd_d),
    .full(full),
    .busy(busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         rise;
    int         fall;
  } pulse_t;

  int         cyc = 0;
  int         vectors = 0;
  int         errors = 0;
  pulse_t     obs[$];
  pulse_t     cur;
  logic       e_prev = 1'b0;
  logic [8:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vectors++;
    if (lcd_rw !== 1'b0) begin
      errors++;
      $display("FAIL rw_low: got %b want 0", lcd_rw);
    end
    if (!rst_n) begin
      e_prev = 1'b0;
    end else begin
      if (lcd_e === 1'b1 && !e_prev) begin
        cur.rs   = lcd_rs;
        cur.d    = lcd_d;
        cur.rise = cyc;
      end else if (lcd_e === 1'b1 || e_prev) begin
        vectors++;
        if (lcd_rs !== cur.rs || lcd_d !== cur.d) begin
          errors++;
          $display("FAIL bus_stable: got %b/%h want %b/%h",
                   lcd_rs, lcd_d, cur.rs, cur.d);
        end
        if (lcd_e !== 1'b1) begin
          cur.fall = cyc;
          obs.push_back(cur);
        end
      end
      e_prev = (lcd_e === 1'b1);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit xlate(input logic [11:0] v, output logic [8:0] o);
    o = 9'h000;
    if (!v[8]) begin
      if (v[7:0] >= 8'h20 && v[7:0] <= 8'h7E) o = {1'b1, v[7:0]};
      else                                   o = {1'b1, 8'h3F};
      return 1'b1;
    end
    if (v[7]) begin
      o = {2'b01, v[6:0]};
      return 1'b1;
    end
    if (v[0]) begin
      o = 9'h001;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endfunction

  task automatic wait_idle(input int budget, output int t);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles want 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr    = 1'b0;
    dbus  = 12'h000;
    repeat (3) @(negedge clk);
    vectors++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_d} !== 11'h000) begin
      errors++;
      $display("FAIL reset_bus: got e=%b rs=%b rw=%b d=%h want 0",
               lcd_e, lcd_rs, lcd_rw, lcd_d);
    end
    vectors++;
    if ({full, overflow, busy} !== 3'b001) begin
      errors++;
      $display("FAIL reset_flags: got full=%b ovf=%b busy=%b want 0/0/1",
               full, overflow, busy);
    end
  endtask

  task automatic test_init();
    int t;
    obs.delete();
    exp_q.delete();
    push_init();
    rst_n = 1'b1;
    wait_idle(8000, t);
    vectors++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL init_count: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({obs[i].rs, obs[i].d} !== exp_q[i]) begin
        errors++;
        $display("FAIL init_byte%0d: got %h want %h",
                 i, {obs[i].rs, obs[i].d}, exp_q[i]);
      end
      vectors++;
      if (obs[i].fall - obs[i].rise !== PULSE) begin
        errors++;
        $display("FAIL init_width%0d: got %0d want %0d",
                 i, obs[i].fall - obs[i].rise, PULSE);
      end
    end
    if (obs.size() == 4) begin
      vectors++;
      if (t - obs[3].fall !== HOLD + CLRW) begin
        errors++;
        $display("FAIL clear_settle: got %0d want %0d",
                 t - obs[3].fall, HOLD + CLRW);
      end
    end
  endtask

  task automatic test_latency();
    int t;
    int t0;
    obs.delete();
    wr   = 1'b1;
    dbus = 12'h041;
    t0   = cyc + 1;
    @(negedge clk);
    wr = 1'b0;
    wait_idle(500, t);
    vectors++;
    if (obs.size() !== 1) begin
      errors++;
      $display("FAIL lat_count: got %0d want 1", obs.size());
    end
    if (obs.size() > 0) begin
      vectors++;
      if ({obs[0].rs, obs[0].d} !== 9'h141) begin
        errors++;
        $display("FAIL lat_byte: got %h want 141", {obs[0].rs, obs[0].d});
      end
      vectors++;
      if (obs[0].rise !== t0 + 1 + SETUP) begin
        errors++;
        $display("FAIL lat_rise: got %0d want %0d", obs[0].rise, t0 + 1 + SETUP);
      end
      vectors++;
      if (obs[0].fall - obs[0].rise !== PULSE) begin
        errors++;
        $display("FAIL lat_width: got %0d want %0d",
                 obs[0].fall - obs[0].rise, PULSE);
      end
    end
  endtask

  task automatic test_translate();
    logic [11:0] v[3];
    logic [8:0]  o;
    int          t;
    v[0] = 12'h007;
    v[1] = 12'h1C5;
    v[2] = 12'h100;
    obs.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      wr   = 1'b1;
      dbus = v[i];
      if (xlate(v[i], o)) exp_q.push_back(o);
      @(negedge clk);
    end
    wr = 1'b0;
    wait_idle(1000, t);
    vectors++;
    if (obs.size() !== 2) begin
      errors++;
      $display("FAIL xl_count: got %0d want 2", obs.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({obs[i].rs, obs[i].d} !== exp_q[i]) begin
        errors++;
        $display("FAIL xl_byte%0d: got %h want %h",
                 i, {obs[i].rs, obs[i].d}, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] v;
    logic [8:0]  o;
    int          t;
    int          k;
    for (int it = 0; it < 14; it++) begin
      obs.delete();
      exp_q.delete();
      k = $urandom_range(1, DEPTH);
      for (int j = 0; j < k; j++) begin
        v = 12'($urandom);
        case ($urandom_range(0, 4))
          0, 1, 2: v[8] = 1'b0;
          3:       v[8:7] = 2'b11;
          default: v[8:7] = 2'b10;
        endcase
        wr   = 1'b1;
        dbus = v;
        if (xlate(v, o)) exp_q.push_back(o);
        @(negedge clk);
      end
      wr = 1'b0;
      wait_idle(4 * CLRW + 1000, t);
      vectors++;
      if (obs.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rnd_count it%0d: got %0d want %0d",
                 it, obs.size(), exp_q.size());
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        vectors++;
        if ({obs[i].rs, obs[i].d} !== exp_q[i]) begin
          errors++;
          $display("FAIL rnd_byte it%0d/%0d: got %h want %h",
                   it, i, {obs[i].rs, obs[i].d}, exp_q[i]);
        end
        vectors++;
        if (obs[i].fall - obs[i].rise !== PULSE) begin
          errors++;
          $display("FAIL rnd_width it%0d/%0d: got %0d want %0d",
                   it, i, obs[i].fall - obs[i].rise, PULSE);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    logic [11:0] v[6];
    int          n;
    int          t;
    int          pop_cyc;
    for (int i = 0; i < 6; i++) v[i] = {4'h0, 8'h41 + 8'(i)};
    obs.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, v[i][7:0]});
    wr   = 1'b1;
    dbus = v[0];
    @(negedge clk);
    wr = 1'b0;
    n  = 0;
    while (lcd_e !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i < 5; i++) begin
      wr   = 1'b1;
      dbus = v[i];
      @(negedge clk);
    end
    wr = 1'b0;
    vectors++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL fp_full_before: got %b want 1", full);
    end
    n = 0;
    while (lcd_e !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    pop_cyc = cyc + HOLD + WAITC + 1;
    while (cyc < pop_cyc - 1) @(negedge clk);
    wr   = 1'b1;
    dbus = v[5];
    @(negedge clk);
    wr = 1'b0;
    vectors++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fp_flags: got full=%b ovf=%b want 1/0", full, overflow);
    end
    wait_idle(2000, t);
    vectors++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL fp_count: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({obs[i].rs, obs[i].d} !== exp_q[i]) begin
        errors++;
        $display("FAIL fp_byte%0d: got %h want %h",
                 i, {obs[i].rs, obs[i].d}, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] v;
    int          t;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    obs.delete();
    exp_q.delete();
    push_init();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      v    = {4'h0, 8'h30 + 8'($urandom_range(0, 9))};
      wr   = 1'b1;
      dbus = v;
      if (i < DEPTH) exp_q.push_back({1'b1, v[7:0]});
      @(negedge clk);
      if (i == DEPTH - 1) begin
        vectors++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ov_fill: got full=%b ovf=%b want 1/0", full, overflow);
        end
      end
    end
    wr = 1'b0;
    vectors++;
    if (full !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ov_drop: got full=%b ovf=%b want 1/1", full, overflow);
    end
    wait_idle(8000, t);
    vectors++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL ov_count: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({obs[i].rs, obs[i].d} !== exp_q[i]) begin
        errors++;
        $display("FAIL ov_byte%0d: got %h want %h",
                 i, {obs[i].rs, obs[i].d}, exp_q[i]);
      end
    end
    vectors++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ov_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_midreset();
    int n;
    int t;
    for (int i = 0; i < 3; i++) begin
      wr   = 1'b1;
      dbus = 12'h05A;
      @(negedge clk);
    end
    wr = 1'b0;
    n  = 0;
    while (lcd_e !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    vectors++;
    if (lcd_e !== 1'b1) begin
      errors++;
      $display("FAIL mr_pulse: got lcd_e=%b want 1", lcd_e);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (lcd_e !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mr_async: got e=%b full=%b ovf=%b busy=%b want 0/0/0/1",
               lcd_e, full, overflow, busy);
    end
    repeat (2) @(negedge clk);
    obs.delete();
    exp_q.delete();
    push_init();
    rst_n = 1'b1;
    wait_idle(8000, t);
    repeat (20) @(negedge clk);
    vectors++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL mr_count: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({obs[i].rs, obs[i].d} !== exp_q[i]) begin
        errors++;
        $display("FAIL mr_byte%0d: got %h want %h",
                 i, {obs[i].rs, obs[i].d}, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_latency();
    test_translate();
    test_random();
    test_full_pop();
    test_overflow();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
